// File: rtl/bm_pkg.sv
// Shared definitions for the block-match frame-buffer read path.
//   - bm_req_t       : identifies a requester (left or right engine)
//   - bm_arb_state_t : read arbiter state
//   - BM_ADDR_W      : frame-buffer address width
//   - BM_BUF_SEL_BIT : address bit selecting one of the two frame buffers
//   - bm_addr_inc    : next word address within the same buffer
package bm_pkg;

  localparam int BM_ADDR_W      = 16;
  localparam int BM_BUF_SEL_BIT = 15;

  typedef enum logic {
    REQ_LEFT  = 1'b0,
    REQ_RIGHT = 1'b1
  } bm_req_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } bm_arb_state_t;

  // The buffer-select bit is held so a burst wraps inside its own buffer.
  function automatic logic [BM_ADDR_W-1:0] bm_addr_inc(input logic [BM_ADDR_W-1:0] a);
    logic [BM_ADDR_W-1:0] r;
    r = a;
    r[BM_BUF_SEL_BIT-1:0] = a[BM_BUF_SEL_BIT-1:0] + 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/bm_rd_tag_pipe.sv
// Latency-matched tag pipeline for the frame-buffer read port.
// Each cycle a tag {valid, owner, last} enters and emerges rd_latency cycles
// later, aligned with the RAM data for the read issued alongside it.
// Ports:
//   clk_i     : clock
//   clr_i     : synchronous clear of all tag valids (active-high)
//   vld_i     : a read is issued this cycle
//   owner_i   : requester owning the read
//   last_i    : read is the final beat of its burst
//   vld_o     : tag valid at the output stage
//   owner_o   : owner at the output stage
//   last_o    : last-beat flag at the output stage
//   any_vld_o : at least one tag anywhere in the pipe is valid
module bm_rd_tag_pipe
  import bm_pkg::*;
#(
  parameter int rd_latency = 2
) (
  input  logic    clk_i,
  input  logic    clr_i,
  input  logic    vld_i,
  input  bm_req_t owner_i,
  input  logic    last_i,
  output logic    vld_o,
  output bm_req_t owner_o,
  output logic    last_o,
  output logic    any_vld_o
);

  logic [rd_latency-1:0] vld_q;
  logic [rd_latency-1:0] own_q;
  logic [rd_latency-1:0] last_q;

  // Valid bits are control: cleared on reset so nothing stale emerges.
  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      vld_q <= '0;
    end else begin
      vld_q[0] <= vld_i;
      for (int i = 1; i < rd_latency; i++) begin
        vld_q[i] <= vld_q[i-1];
      end
    end
  end

  // Owner/last are qualified by valid, so they need no reset.
  always_ff @(posedge clk_i) begin
    own_q[0]  <= owner_i;
    last_q[0] <= last_i;
    for (int i = 1; i < rd_latency; i++) begin
      own_q[i]  <= own_q[i-1];
      last_q[i] <= last_q[i-1];
    end
  end

  assign vld_o     = vld_q[rd_latency-1];
  assign owner_o   = bm_req_t'(own_q[rd_latency-1]);
  assign last_o    = last_q[rd_latency-1];
  assign any_vld_o = |vld_q;

endmodule

// File: rtl/bm_read_arbiter.sv
// Frame-buffer read-port arbiter for the left and right block-match engines.
// Grants one burst of burst_words consecutive reads at a time, drives the RAM
// read port and steers returned data back to the burst owner through a tag
// pipeline matched to the RAM read latency. A grant on the final beat of a
// burst chains the next burst with no idle cycle on the RAM port.
// Configuration macro:
//   BM_ARB_FIXED_PRIO_EN : defined -> LEFT always wins a tie (fixed priority);
//                          undefined -> round-robin on last owner.
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   req_left/right, addr_*     : burst request and start address (bit 15 = buffer)
//   gnt_left/right             : request accepted this cycle (combinational)
//   rvalid_*, rdata_*, done_*  : returned word, data and last-word pulse
//   ram_rd_en, ram_addr        : RAM read strobe and address
//   ram_rdata                  : RAM read data
//   busy                       : burst issuing or reads still in flight
module bm_read_arbiter
  import bm_pkg::*;
#(
  parameter int rd_port_w   = 8,
  parameter int burst_words = 8,
  parameter int rd_latency  = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_left,
  input  logic                 req_right,
  input  logic [BM_ADDR_W-1:0] addr_left,
  input  logic [BM_ADDR_W-1:0] addr_right,
  output logic                 gnt_left,
  output logic                 gnt_right,
  output logic                 rvalid_left,
  output logic                 rvalid_right,
  output logic [rd_port_w-1:0] rdata_left,
  output logic [rd_port_w-1:0] rdata_right,
  output logic                 done_left,
  output logic                 done_right,
  output logic                 ram_rd_en,
  output logic [BM_ADDR_W-1:0] ram_addr,
  input  logic [rd_port_w-1:0] ram_rdata,
  output logic                 busy
);

  localparam int BEAT_W = (burst_words > 1) ? $clog2(burst_words) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(burst_words - 1);

  bm_arb_state_t        state_q, state_d;
  logic [BEAT_W-1:0]    beat_q, beat_d;
  logic [BM_ADDR_W-1:0] addr_cnt_q, addr_cnt_d;
  bm_req_t              owner_q, owner_d;

  logic    last_beat;
  logic    accept;
  bm_req_t sel;

  logic    tag_vld;
  bm_req_t tag_owner;
  logic    tag_last;
  logic    tag_any;

  assign last_beat = (state_q == ST_BURST) && (beat_q == LAST_BEAT);
  assign accept    = ((state_q == ST_IDLE) || last_beat) && (req_left || req_right);

`ifdef BM_ARB_FIXED_PRIO_EN
  always_comb begin
    sel = req_left ? REQ_LEFT : REQ_RIGHT;
  end
`else
  bm_req_t last_owner_q, last_owner_d;

  // On a tie the requester that did not own the previous grant wins.
  always_comb begin
    sel = REQ_LEFT;
    if (req_left && req_right) begin
      sel = (last_owner_q == REQ_RIGHT) ? REQ_LEFT : REQ_RIGHT;
    end else if (req_right) begin
      sel = REQ_RIGHT;
    end
  end

  always_comb begin
    last_owner_d = last_owner_q;
    if (accept) begin
      last_owner_d = sel;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_owner_q <= REQ_RIGHT;
    end else begin
      last_owner_q <= last_owner_d;
    end
  end
`endif

  assign gnt_left  = accept && (sel == REQ_LEFT);
  assign gnt_right = accept && (sel == REQ_RIGHT);

  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    addr_cnt_d = addr_cnt_q;
    owner_d    = owner_q;
    if (accept) begin
      state_d    = ST_BURST;
      beat_d     = '0;
      owner_d    = sel;
      addr_cnt_d = (sel == REQ_LEFT) ? addr_left : addr_right;
    end else if (last_beat) begin
      state_d = ST_IDLE;
    end else if (state_q == ST_BURST) begin
      beat_d     = beat_q + 1'b1;
      addr_cnt_d = bm_addr_inc(addr_cnt_q);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    beat_q     <= beat_d;
    addr_cnt_q <= addr_cnt_d;
    owner_q    <= owner_d;
  end

  // RAM issue stage: one read per burst cycle.
  assign ram_rd_en = (state_q == ST_BURST);
  assign ram_addr  = ram_rd_en ? addr_cnt_q : '0;

  // Return stage: tags emerge with the RAM data rd_latency cycles later.
  bm_rd_tag_pipe #(
    .rd_latency(rd_latency)
  ) u_tag_pipe (
    .clk_i    (clk),
    .clr_i    (reset),
    .vld_i    (ram_rd_en),
    .owner_i  (owner_q),
    .last_i   (last_beat),
    .vld_o    (tag_vld),
    .owner_o  (tag_owner),
    .last_o   (tag_last),
    .any_vld_o(tag_any)
  );

  assign rvalid_left  = tag_vld && (tag_owner == REQ_LEFT);
  assign rvalid_right = tag_vld && (tag_owner == REQ_RIGHT);
  assign done_left    = rvalid_left && tag_last;
  assign done_right   = rvalid_right && tag_last;
  assign rdata_left   = ram_rdata;
  assign rdata_right  = ram_rdata;

  assign busy = (state_q == ST_BURST) || tag_any;

endmodule

// File: tb/tb_bm_read_arbiter.sv
module tb_bm_read_arbiter;

  localparam int W  = 8;
  localparam int BW = 8;
  localparam int L  = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_left, req_right;
  logic [15:0] addr_left, addr_right;
  logic        gnt_left, gnt_right;
  logic        rvalid_left, rvalid_right;
  logic [W-1:0] rdata_left, rdata_right;
  logic        done_left, done_right;
  logic        ram_rd_en;
  logic [15:0] ram_addr;
  logic [W-1:0] ram_rdata;
  logic        busy;

  always #5 clk = ~clk;

  bm_read_arbiter #(
    .rd_port_w  (W),
    .burst_words(BW),
    .rd_latency (L)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_left    (req_left),
    .req_right   (req_right),
    .addr_left   (addr_left),
    .addr_right  (addr_right),
    .gnt_left    (gnt_left),
    .gnt_right   (gnt_right),
    .rvalid_left (rvalid_left),
    .rvalid_right(rvalid_right),
    .rdata_left  (rdata_left),
    .rdata_right (rdata_right),
    .done_left   (done_left),
    .done_right  (done_right),
    .ram_rd_en   (ram_rd_en),
    .ram_addr    (ram_addr),
    .ram_rdata   (ram_rdata),
    .busy        (busy)
  );

  // RAM: data is a fixed function of address, returned L cycles after the read.
  function automatic logic [W-1:0] mem_f(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  logic [W-1:0] rp [L];
  always @(posedge clk) begin
    rp[0] <= mem_f(ram_addr);
    for (int i = 1; i < L; i++) rp[i] <= rp[i-1];
  end
  assign ram_rdata = rp[L-1];

  // Scoreboard queues of expected RAM reads and expected returned words.
  typedef struct { int cyc; logic [15:0] addr; } rd_t;
  typedef struct { int cyc; logic own; logic [W-1:0] data; logic last; } ret_t;
  rd_t  rdq[$];
  ret_t retq[$];

  int   cyc = 0;
  int   next_acc = 0;
  logic last_owner = 1'b1;      // 0 = left, 1 = right
  logic g_l, g_r;
  logic exp_gl = 1'b0, exp_gr = 1'b0;
  int   n_chk = 0, n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    else n_pass++;
  endtask

  // Drive one cycle of inputs, predict the grant from the arbitration rules,
  // schedule its reads/returns, then advance to just after the clock edge.
  task automatic step(input logic rl, input logic rr, input logic [15:0] al,
                      input logic [15:0] ar, input logic rs);
    logic        win;
    logic [15:0] a;
    req_left = rl; req_right = rr; addr_left = al; addr_right = ar; reset = rs;
    g_l = 1'b0; g_r = 1'b0;
    if (cyc >= next_acc && (rl || rr)) begin
      if (rl && rr) begin
`ifdef BM_ARB_FIXED_PRIO_EN
        win = 1'b0;
`else
        win = ~last_owner;
`endif
      end else begin
        win = rr && !rl;
      end
      last_owner = win;
      next_acc = cyc + BW;
      a = win ? ar : al;
      for (int k = 0; k < BW; k++) begin
        logic [15:0] ak;
        ak = {a[15], a[14:0] + 15'(k)};
        rdq.push_back('{cyc + 1 + k, ak});
        retq.push_back('{cyc + 1 + L + k, win, mem_f(ak), k == BW - 1});
      end
      g_l = !win; g_r = win;
    end
    exp_gl = g_l; exp_gr = g_r;
    @(posedge clk); #1;
    cyc++;
    if (rs) begin
      rdq.delete(); retq.delete();
      next_acc = 0; last_owner = 1'b1;
    end
  endtask

  // Monitor: compares every DUT output against the scoreboard each cycle.
  always @(negedge clk) begin
    if (cyc >= 1) begin
      logic eb;
      rd_t  r;
      ret_t t;
      chk("gnt_left", gnt_left, exp_gl);
      chk("gnt_right", gnt_right, exp_gr);
      eb = (retq.size() > 0) && (retq[0].cyc <= cyc + L);
      chk("busy", busy, eb);
      if (rdq.size() > 0 && rdq[0].cyc == cyc) begin
        r = rdq.pop_front();
        chk("ram_rd_en", ram_rd_en, 1);
        chk("ram_addr", ram_addr, r.addr);
      end else begin
        chk("ram_rd_en_idle", ram_rd_en, 0);
      end
      if (retq.size() > 0 && retq[0].cyc == cyc) begin
        t = retq.pop_front();
        chk("rvalid_left", rvalid_left, !t.own);
        chk("rvalid_right", rvalid_right, t.own);
        chk("done_left", done_left, !t.own && t.last);
        chk("done_right", done_right, t.own && t.last);
        chk("rdata", t.own ? rdata_right : rdata_left, t.data);
      end else begin
        chk("rvalid_idle", {rvalid_left, rvalid_right, done_left, done_right}, 0);
      end
    end
  end

  initial begin
    logic        pl, pr;
    logic [15:0] al, ar;
    int          n;

    repeat (3) step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    chk("reset_ram_addr", ram_addr, 0);

    // Left-only burst at 0x0100.
    step(1, 0, 16'h0100, 0, 0);
    repeat (14) step(0, 0, 0, 0, 0);

    // Simultaneous requests straight after reset: left first, right chained.
    step(0, 0, 0, 0, 1);
    pl = 1; pr = 1;
    for (int i = 0; i < 24; i++) begin
      step(pl, pr, 16'h0000, 16'h8040, 0);
      if (g_l) pl = 0;
      if (g_r) pr = 0;
    end

    // Both requesting continuously for four bursts.
    n = 0; al = 16'h1000; ar = 16'h9000;
    for (int i = 0; i < 60 && n < 4; i++) begin
      step(1, 1, al, ar, 0);
      if (g_l) begin n++; al = al + 16'h0020; end
      if (g_r) begin n++; ar = ar + 16'h0020; end
    end
    repeat (12) step(0, 0, 0, 0, 0);

    // Right burst wrapping at the top of buffer 1.
    step(0, 1, 0, 16'hFFFC, 0);
    repeat (14) step(0, 0, 0, 0, 0);

    // Reset during beat 3 of a left burst.
    step(1, 0, 16'h0200, 0, 0);
    repeat (3) step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    repeat (6) step(0, 0, 0, 0, 0);

    // Right request withdrawn while the left burst is running.
    step(1, 0, 16'h0300, 0, 0);
    repeat (2) step(0, 1, 0, 16'h1234, 0);
    repeat (14) step(0, 0, 0, 0, 0);

    // Randomized traffic with queued bursts, withdrawals and rare resets.
    pl = 0; pr = 0; al = 0; ar = 0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        step(0, 0, al, ar, 1);
        pl = 0; pr = 0;
      end else begin
        step(pl, pr, al, ar, 0);
        if (g_l) begin pl = $urandom_range(0, 1); al = 16'($urandom); end
        else if (pl && $urandom_range(0, 15) == 0) pl = 0;
        else if (!pl && $urandom_range(0, 3) == 0) begin pl = 1; al = 16'($urandom); end
        if (g_r) begin pr = $urandom_range(0, 1); ar = 16'($urandom); end
        else if (pr && $urandom_range(0, 15) == 0) pr = 0;
        else if (!pr && $urandom_range(0, 3) == 0) begin pr = 1; ar = 16'($urandom); end
      end
    end
    repeat (14) step(0, 0, 0, 0, 0);
    chk("final_rdq_empty", rdq.size(), 0);
    chk("final_retq_empty", retq.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/bm_read_arbiter.md
# bm_read_arbiter

Shares a single frame-buffer read port between the left and right block-match engines. Each engine requests a burst of consecutive words, one search-window row, from a start address. The arbiter grants one requester at a time, issues the burst to the RAM and routes the returned data back to the owner using a latency-matched tag pipeline. It sits between the block-match engines and the dual-buffered bit-frame RAM. Back-to-back bursts run with no idle cycles on the RAM port.

## Interface
- `rd_port_w`, 8, RAM read data width in bits
- `burst_words`, 8, reads per burst (search_blk_w / rd_port_w)
- `rd_latency`, 2, RAM read latency in cycles (rd_en to rdata valid), ≥1
- `clk`  in  1  sole clock
- `reset`  in  1  synchronous, active-high
- `req_left` / `req_right`  in  1  burst request; held with address until granted
- `addr_left` / `addr_right`  in  16  burst start address; bit 15 = buffer select
- `gnt_left` / `gnt_right`  out  1  one-cycle pulse: request accepted this cycle
- `rvalid_left` / `rvalid_right`  out  1  returned word valid for this requester
- `rdata_left` / `rdata_right`  out  rd_port_w  returned data (both driven from ram_rdata)
- `done_left` / `done_right`  out  1  pulse coincident with the last rvalid of a burst
- `ram_rd_en`  out  1  RAM read strobe
- `ram_addr`  out  16  RAM read address
- `ram_rdata`  in  rd_port_w  RAM read data
- `busy`  out  1  burst issuing or tag pipeline non-empty

## Operation
- States: ST_IDLE, ST_BURST.
- Accept point: the cycle where (state==ST_IDLE) or (state==ST_BURST and beat==burst_words-1), with at least one req high.
  - At the accept point, gnt of the selected requester is asserted combinationally.
  - Registered on the accept: owner, addr_cnt←addr_x, beat←0, state←ST_BURST.
- No req at the last beat: state←ST_IDLE.
- ST_BURST:
  - ram_rd_en=1, ram_addr=addr_cnt.
  - Each cycle: beat++, addr_cnt[14:0]++ modulo 2^15. addr_cnt[15] is held, so a burst never crosses buffers.
- Arbitration, default round-robin:
  - Single requester: that requester wins.
  - Both requesting: the requester that is not last_owner wins.
  - last_owner updates on each grant. Reset value = RIGHT, so LEFT wins the first tie.
- Tag pipeline: rd_latency stages of {valid, owner, last}, fed each cycle by {ram_rd_en, owner, beat==burst_words-1}.
  - Final stage drives rvalid_x = valid & owner==x, and done_x = rvalid_x & last.
- Requester protocol:
  - Deassert req the cycle after gnt, or keep it high with a new address to queue the next burst.
  - A req that drops before gnt is a legal withdrawal. No read is issued for it.
- busy = (state==ST_BURST) | any tag valid.

## Timing
- Reset values:
  - state=ST_IDLE, last_owner=RIGHT, tag valids cleared.
  - All gnt, rvalid, done, ram_rd_en and busy outputs = 0.
  - ram_addr=0.
- Grant accepted in cycle T:
  - First ram_rd_en in T+1.
  - Last ram_rd_en in T+burst_words.
  - First rvalid in T+1+rd_latency.
  - done in T+burst_words+rd_latency.
- Back-to-back: a grant on the last beat makes the next burst's first read immediately follow, so ram_rd_en stays high continuously.
- Reset mid-burst: the burst is aborted, tags are flushed, and no rvalid or done is emitted after the reset cycle.
- addr_cnt wrap 0x7FFF→0x0000 stays within the same buffer (bit 15 unchanged).

## Configuration
- `BM_ARB_FIXED_PRIO_EN` defined: fixed priority. LEFT always wins a tie; last_owner is unused.
- Not defined: round-robin as above.

## Structure
- Shared package `bm_pkg`:
  - `typedef enum {REQ_LEFT, REQ_RIGHT} bm_req_t`.
  - The arbiter state enum.
  - Constants `BM_ADDR_W=16` and `BM_BUF_SEL_BIT=15`.
- Sub-module `bm_rd_tag_pipe`: rd_latency-deep shift register of {valid, owner, last}, with synchronous clear.

## Test plan
- Left-only request, addr=0x0100, rd_latency=2:
  - gnt_left in T.
  - ram_addr 0x0100..0x0107 in T+1..T+8.
  - rvalid_left T+3..T+10, done_left at T+10.
  - No right outputs.
- Simultaneous requests from reset (left 0x0000, right 0x8040):
  - Left granted first; right granted on the left's last beat.
  - ram_rd_en high for 16 contiguous cycles; the second burst reads 0x8040..0x8047.
- Both requesting continuously for 4 bursts: grants alternate L,R,L,R. With `BM_ARB_FIXED_PRIO_EN`: L,L,L,L.
- Wrap: right addr=0xFFFC → ram_addr FFFC,FFFD,FFFE,FFFF,8000,8001,8002,8003.
- Reset asserted at beat 3 of a left burst: ram_rd_en=0 next cycle; no further rvalid_left or done_left; busy=0.
- req_right withdrawn before a grant while the left burst runs: no gnt_right, no right reads issued, state→ST_IDLE after the left burst.
